// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: icache (read-only) and dcache (read/write) share one memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise dcache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_rw,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   ic_resp_valid,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,
    output logic                   orphan_err
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TAG_DEPTH);

    typedef enum logic {IDLE, WDATA} state_t;

    state_t               state, state_nxt;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 fifo_full, fifo_empty, rd_ok;
    logic                 ic_elig, dc_elig, grant_dc, any_elig, req_fire;
    logic                 push, pop, head_dc;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // A read may issue into a full FIFO when a response frees a slot this same cycle.
    assign rd_ok      = !fifo_full || mem_resp_valid;
    assign ic_elig    = ic_req_valid && rd_ok;
    assign dc_elig    = dc_req_valid && (dc_req_rw || rd_ok);
    assign any_elig   = ic_elig || dc_elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dc;
    assign grant_dc = dc_elig && !(ic_elig && last_dc);

    always_ff @(posedge clk) begin
        if (reset)         last_dc <= 1'b0;
        else if (req_fire) last_dc <= grant_dc;
    end
`else
    assign grant_dc = dc_elig;
`endif

    assign pop     = mem_resp_valid && !fifo_empty;
    assign head_dc = tag_mem[rd_ptr];

    assign mem_req_addr      = grant_dc ? dc_req_addr : ic_req_addr;
    assign mem_req_data_bits = dc_req_data_bits;
    assign mem_req_data_mask = dc_req_data_mask;
    assign resp_data         = mem_resp_data;
    assign ic_resp_valid     = !reset && pop && !head_dc;
    assign dc_resp_valid     = !reset && pop && head_dc;

    always_comb begin
        state_nxt          = state;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        mem_req_data_valid = 1'b0;
        dc_req_data_ready  = 1'b0;
        req_fire           = 1'b0;
        push               = 1'b0;
        case (state)
            IDLE: begin
                mem_req_valid = any_elig;
                mem_req_rw    = grant_dc && dc_req_rw;
                ic_req_ready  = ic_elig && !grant_dc && mem_req_ready;
                dc_req_ready  = grant_dc && mem_req_ready;
                req_fire      = any_elig && mem_req_ready;
                push          = req_fire && !mem_req_rw;
                if (req_fire && mem_req_rw) begin
                    mem_req_data_valid = dc_req_data_valid;
                    dc_req_data_ready  = mem_req_data_ready;
                    if (!(dc_req_data_valid && mem_req_data_ready))
                        state_nxt = WDATA;
                end
            end
            WDATA: begin
                mem_req_data_valid = dc_req_data_valid;
                dc_req_data_ready  = mem_req_data_ready;
                if (dc_req_data_valid && mem_req_data_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Memory is reset alongside us, so nothing may handshake during reset.
        if (reset) begin
            mem_req_valid      = 1'b0;
            ic_req_ready       = 1'b0;
            dc_req_ready       = 1'b0;
            mem_req_data_valid = 1'b0;
            dc_req_data_ready  = 1'b0;
            req_fire           = 1'b0;
            push               = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            orphan_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (mem_resp_valid && fifo_empty) orphan_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant_dc;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a queue-based reference model.
module tb_mem_arbiter;
    localparam int AB = 28;
    localparam int DB = 128;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready;
    logic [AB-1:0] ic_req_addr;
    logic          dc_req_valid, dc_req_ready;
    logic [AB-1:0] dc_req_addr;
    logic          dc_req_rw, dc_req_data_valid, dc_req_data_ready;
    logic [DB-1:0] dc_req_data_bits;
    logic [DB/8-1:0] dc_req_data_mask;
    logic          ic_resp_valid, dc_resp_valid;
    logic [DB-1:0] resp_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AB-1:0] mem_req_addr;
    logic          mem_req_rw, mem_req_data_valid, mem_req_data_ready;
    logic [DB-1:0] mem_req_data_bits;
    logic [DB/8-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DB-1:0] mem_resp_data;
    logic          orphan_err;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
        .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
        .dc_req_data_mask(dc_req_data_mask),
        .ic_resp_valid(ic_resp_valid), .dc_resp_valid(dc_resp_valid), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, want, $time);
        end
    endtask

    // Reference model: outstanding reads as a queue of client ids (0 = ic, 1 = dc).
    int mq[$];
    bit m_wdata, m_orphan, m_last_dc;

    always @(negedge clk) begin : model
        bit full, rd_ok, ic_e, dc_e, win_dc, any, acc, wr;
        bit e_dv, e_dr, e_icr, e_dcr;
        int head;
        if (reset) begin
            chk("rst_mem_req_valid", mem_req_valid, 0);
            chk("rst_ic_req_ready", ic_req_ready, 0);
            chk("rst_dc_req_ready", dc_req_ready, 0);
            chk("rst_data_valid", mem_req_data_valid, 0);
            chk("rst_data_ready", dc_req_data_ready, 0);
            chk("rst_resp", {ic_resp_valid, dc_resp_valid}, 0);
            mq.delete();
            m_wdata = 0; m_orphan = 0; m_last_dc = 0;
        end else begin
            chk("orphan_err", orphan_err, m_orphan);
            chk("data_bits", mem_req_data_bits, dc_req_data_bits);
            chk("data_mask", mem_req_data_mask, dc_req_data_mask);
            full  = (mq.size() == DEPTH);
            rd_ok = !full || mem_resp_valid;
            ic_e  = !m_wdata && ic_req_valid && rd_ok;
            dc_e  = !m_wdata && dc_req_valid && (dc_req_rw || rd_ok);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_dc = dc_e && !(ic_e && m_last_dc);
`else
            win_dc = dc_e;
`endif
            any = ic_e || dc_e;
            acc = any && mem_req_ready;
            wr  = acc && win_dc && dc_req_rw;
            e_icr = acc && !win_dc;
            e_dcr = acc && win_dc;
            e_dv = 0; e_dr = 0;
            if (m_wdata || wr) begin
                e_dv = dc_req_data_valid;
                e_dr = mem_req_data_ready;
            end
            chk("mem_req_valid", mem_req_valid, any);
            if (any) begin
                chk("mem_req_addr", mem_req_addr, win_dc ? dc_req_addr : ic_req_addr);
                chk("mem_req_rw", mem_req_rw, win_dc && dc_req_rw);
            end
            chk("ic_req_ready", ic_req_ready, e_icr);
            chk("dc_req_ready", dc_req_ready, e_dcr);
            chk("mem_req_data_valid", mem_req_data_valid, e_dv);
            chk("dc_req_data_ready", dc_req_data_ready, e_dr);
            head = -1;
            if (mem_resp_valid) begin
                chk("resp_data", resp_data, mem_resp_data);
                if (mq.size() > 0) head = mq.pop_front();
                else m_orphan = 1;
            end
            chk("ic_resp_valid", ic_resp_valid, head == 0);
            chk("dc_resp_valid", dc_resp_valid, head == 1);
            if (acc && !wr) mq.push_back(win_dc ? 1 : 0);
            if (acc) m_last_dc = win_dc;
            if (m_wdata) m_wdata = !(dc_req_data_valid && mem_req_data_ready);
            else if (wr) m_wdata = !(dc_req_data_valid && mem_req_data_ready);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        ic_req_valid = 0; dc_req_valid = 0; dc_req_rw = 0; dc_req_data_valid = 0;
        mem_resp_valid = 0;
    endtask

    task automatic do_reset();
        step(); reset = 1; idle_inputs();
        smp();
        step(); reset = 0;
    endtask

    initial begin
        logic [DB-1:0] wdat;
        reset = 1; idle_inputs();
        ic_req_addr = '0; dc_req_addr = '0; dc_req_data_bits = '0; dc_req_data_mask = '0;
        mem_req_ready = 1; mem_req_data_ready = 1; mem_resp_data = '0;
        repeat (3) @(posedge clk);
        smp();
        chk("t0_reset_valid", mem_req_valid, 0);
        step(); reset = 0;
        smp();
        chk("t0_orphan_clear", orphan_err, 0);

        // both read: dc first, then ic; responses routed in order
        step(); dc_req_valid = 1; dc_req_addr = 'h100; ic_req_valid = 1; ic_req_addr = 'h200;
        smp(); chk("t1_addr0", mem_req_addr, 'h100); chk("t1_ic_blocked", ic_req_ready, 0);
        step(); dc_req_valid = 0;
        smp(); chk("t1_addr1", mem_req_addr, 'h200); chk("t1_ic_ready", ic_req_ready, 1);
        step(); ic_req_valid = 0; mem_resp_valid = 1; mem_resp_data = {16{8'hAA}};
        smp(); chk("t1_resp0_dc", {ic_resp_valid, dc_resp_valid}, 2'b01);
        chk("t1_resp0_data", resp_data, {16{8'hAA}});
        step(); mem_resp_data = {16{8'hBB}};
        smp(); chk("t1_resp1_ic", {ic_resp_valid, dc_resp_valid}, 2'b10);
        step(); mem_resp_valid = 0;

        // fill FIFO with dc reads; ic blocked unless a response pops this cycle
        dc_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            dc_req_addr = AB'(i); smp(); step();
        end
        dc_req_valid = 0; ic_req_valid = 1; ic_req_addr = 'h44;
        smp(); chk("t2_full_block", ic_req_ready, 0); chk("t2_full_noreq", mem_req_valid, 0);
        step(); mem_resp_valid = 1;
        smp(); chk("t2_pop_grant", ic_req_ready, 1); chk("t2_pop_resp", dc_resp_valid, 1);
        step(); mem_resp_valid = 0;
        smp(); chk("t2_still_full", ic_req_ready, 0);
        step(); ic_req_valid = 0; mem_resp_valid = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t2_drain", {ic_resp_valid, dc_resp_valid}, (i == 3) ? 2'b10 : 2'b01);
            step();
        end
        mem_resp_valid = 0;

        // write with lagging data blocks the port
        wdat = {$urandom, $urandom, $urandom, $urandom};
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 'h10; dc_req_data_bits = wdat;
        dc_req_data_mask = 16'h000F; ic_req_valid = 1; ic_req_addr = 'h300;
        smp(); chk("t3_wr_addr", mem_req_addr, 'h10); chk("t3_wr_rw", mem_req_rw, 1);
        chk("t3_no_data", mem_req_data_valid, 0);
        step(); dc_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            smp(); chk("t3_blocked", {mem_req_valid, ic_req_ready}, 2'b00); step();
        end
        dc_req_data_valid = 1;
        smp(); chk("t3_data_valid", mem_req_data_valid, 1); chk("t3_blocked3", mem_req_valid, 0);
        chk("t3_bits", mem_req_data_bits, wdat); chk("t3_mask", mem_req_data_mask, 16'h000F);
        step(); dc_req_data_valid = 0; dc_req_rw = 0;
        smp(); chk("t3_ic_after", mem_req_addr, 'h300); chk("t3_ic_rdy", ic_req_ready, 1);
        step(); ic_req_valid = 0; mem_resp_valid = 1;
        smp(); chk("t3_ic_resp", ic_resp_valid, 1);

        // orphan response
        step();
        smp(); chk("t4_no_resp", {ic_resp_valid, dc_resp_valid}, 0);
        step(); mem_resp_valid = 0;
        smp(); chk("t4_orphan_set", orphan_err, 1);
        step(); smp(); chk("t4_orphan_hold", orphan_err, 1);
        do_reset();
        smp(); chk("t4_orphan_rst", orphan_err, 0);

        // contended continuous reads
        step(); dc_req_valid = 1; dc_req_addr = 'h100; ic_req_valid = 1; ic_req_addr = 'h200;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            smp(); chk("t5_rr_grant", mem_req_addr, (i % 2 == 0) ? 'h100 : 'h200);
`else
            smp(); chk("t5_fixed_grant", mem_req_addr, 'h100);
`endif
            step();
        end
        do_reset();

        // reset while in WDATA with reads outstanding
        dc_req_valid = 1; dc_req_rw = 0;
        smp(); step(); smp(); step();
        dc_req_rw = 1; dc_req_data_valid = 0;
        smp(); chk("t6_wr_acc", dc_req_ready, 1);
        step(); dc_req_valid = 0; dc_req_rw = 0; reset = 1; dc_req_data_valid = 1;
        smp(); chk("t6_rst_data", mem_req_data_valid, 0);
        step(); reset = 0;
        smp(); chk("t6_idle_data", mem_req_data_valid, 0); chk("t6_idle_drdy", dc_req_data_ready, 0);
        step(); dc_req_data_valid = 0; mem_resp_valid = 1;
        smp(); chk("t6_fifo_empty", {ic_resp_valid, dc_resp_valid}, 0);
        step(); mem_resp_valid = 0;
        smp(); chk("t6_orphan", orphan_err, 1);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            ic_req_valid = $urandom_range(0, 1);
            ic_req_addr = AB'($urandom);
            dc_req_valid = $urandom_range(0, 1);
            dc_req_addr = AB'($urandom);
            dc_req_rw = ($urandom_range(0, 2) == 0);
            dc_req_data_valid = $urandom_range(0, 1);
            dc_req_data_bits = {$urandom, $urandom, $urandom, $urandom};
            dc_req_data_mask = 16'($urandom);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_req_data_ready = ($urandom_range(0, 3) != 0);
            mem_resp_valid = (mq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 199) == 0);
            mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
        end
        step(); reset = 0; idle_inputs();
        smp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
